// File: rtl/periph_arb_pkg.sv
// Shared types and helpers for the peripheral round-robin arbiter.
// Holds the arbiter state encoding and the rotating-priority pick.
package periph_arb_pkg;

   localparam int MAX_MASTERS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
   function automatic logic [2:0] rr_pick(
      input logic [7:0] req,
      input logic [2:0] ptr,
      input logic [3:0] n
   );
      logic [3:0] j;
      logic       found;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 0; k < MAX_MASTERS; k++) begin
         j = 4'(ptr) + 4'(k);
         if (j >= n) j = j - n;
         if (!found && (4'(k) < n) && req[j[2:0]]) begin
            rr_pick = j[2:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// HWPE peripheral request/response bundle.
// wen is active-low (0 = write, 1 = read).
interface hwpe_ctrl_intf_periph #(
   parameter int unsigned ID_WIDTH = 8
) ();

   logic                req;
   logic                gnt;
   logic [31:0]         add;
   logic                wen;
   logic [3:0]          be;
   logic [31:0]         data;
   logic [ID_WIDTH-1:0] id;
   logic [31:0]         r_data;
   logic                r_valid;
   logic [ID_WIDTH-1:0] r_id;

   modport master (
      output req, add, wen, be, data, id,
      input  gnt, r_data, r_valid, r_id
   );

   modport slave (
      input  req, add, wen, be, data, id,
      output gnt, r_data, r_valid, r_id
   );

endinterface

// File: rtl/periph_rr_arbiter_rr_prio_select.sv
// Combinational round-robin pick from a request vector.
// Scan starts at ptr and wraps at N_MASTERS.
module rr_prio_select
   import periph_arb_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int IW        = $clog2(N_MASTERS)
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [IW-1:0]        ptr,
   output logic [IW-1:0]        idx,
   output logic                 valid
);

   logic [2:0] pick;

   // Widen to the helper's fixed width and pick the winner.
   always_comb begin
      pick = rr_pick(8'(req), 3'(ptr), 4'(N_MASTERS));
   end

   assign idx   = IW'(pick);
   assign valid = |req;

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin merge of N peripheral masters onto one slave port.
// One transaction in flight; owner locked from request to response.
module periph_rr_arbiter
   import periph_arb_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ID_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   hwpe_ctrl_intf_periph.slave          in [N_MASTERS],
   hwpe_ctrl_intf_periph.master         out,
   output logic                         busy,
   output logic [$clog2(N_MASTERS)-1:0] owner
);

   localparam int OW = $clog2(N_MASTERS);

   arb_state_e state;
   logic [OW-1:0] rr_ptr;
   logic [OW-1:0] nxt_ptr;
   logic [OW-1:0] pick_idx;
   logic          pick_vld;
   logic          req_q;
   logic          resp_ok;

   logic [N_MASTERS-1:0] req_v;
   logic [31:0]          add_v  [N_MASTERS];
   logic                 wen_v  [N_MASTERS];
   logic [3:0]           be_v   [N_MASTERS];
   logic [31:0]          data_v [N_MASTERS];
   logic [ID_WIDTH-1:0]  id_v   [N_MASTERS];

   rr_prio_select #(
      .N_MASTERS (N_MASTERS),
      .IW        (OW)
   ) u_sel (
      .req   (req_v),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // A response completes in RESP, or in FWD when it lands with gnt.
   assign resp_ok = out.r_valid &&
                    ((state == RESP) ||
                     ((state == FWD) && out.gnt));

   assign nxt_ptr = (owner == OW'(N_MASTERS - 1)) ?
                    '0 : owner + 1'b1;

   // Interface arrays need constant indices, so flatten here.
   for (genvar g = 0; g < N_MASTERS; g++) begin : g_m
      logic sel;
      assign sel           = (owner == OW'(g));
      assign req_v[g]      = in[g].req;
      assign add_v[g]      = in[g].add;
      assign wen_v[g]      = in[g].wen;
      assign be_v[g]       = in[g].be;
      assign data_v[g]     = in[g].data;
      assign id_v[g]       = in[g].id;
      assign in[g].gnt     = req_q && sel && out.gnt;
      assign in[g].r_valid = sel && resp_ok;
      assign in[g].r_data  = (sel && resp_ok) ?
                             out.r_data : '0;
      assign in[g].r_id    = (sel && resp_ok) ?
                             out.r_id : '0;
   end

   assign out.req  = req_q;
   assign out.add  = req_q ? add_v[owner]  : '0;
   assign out.wen  = req_q ? wen_v[owner]  : 1'b0;
   assign out.be   = req_q ? be_v[owner]   : '0;
   assign out.data = req_q ? data_v[owner] : '0;
   assign out.id   = req_q ? id_v[owner]   : '0;

   // Owner-locked transaction sequencer with registered req/busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         busy   <= 1'b0;
         req_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  owner <= pick_idx;
                  state <= FWD;
                  busy  <= 1'b1;
                  req_q <= 1'b1;
               end
            end
            FWD: begin
               if (out.gnt) begin
                  req_q <= 1'b0;
                  if (out.r_valid) begin
                     rr_ptr <= nxt_ptr;
                     state  <= IDLE;
                     busy   <= 1'b0;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (out.r_valid) begin
                  rr_ptr <= nxt_ptr;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Bench for periph_rr_arbiter: directed scenarios, then random traffic.
// A transaction-level model predicts every master and bridge output.
module tb_periph_rr_arbiter;

   localparam int N   = 2;
   localparam int IDW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hwpe_ctrl_intf_periph #(.ID_WIDTH(IDW)) m_if [N] ();
   hwpe_ctrl_intf_periph #(.ID_WIDTH(IDW)) s_if ();

   logic       busy;
   logic [0:0] owner;

   periph_rr_arbiter #(
      .N_MASTERS (N),
      .ID_WIDTH  (IDW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .in    (m_if),
      .out   (s_if),
      .busy  (busy),
      .owner (owner)
   );

   logic           mreq  [N];
   logic           mwen  [N];
   logic [31:0]    madd  [N];
   logic [3:0]     mbe   [N];
   logic [31:0]    mdata [N];
   logic [IDW-1:0] mid   [N];
   logic           keep  [N];

   logic           dgnt  [N];
   logic           drv   [N];
   logic [31:0]    drdat [N];
   logic [IDW-1:0] drid  [N];

   logic           b_gnt, b_rv;
   logic [31:0]    b_rdata;
   logic [IDW-1:0] b_rid;

   for (genvar g = 0; g < N; g++) begin : g_c
      assign m_if[g].req  = mreq[g];
      assign m_if[g].wen  = mwen[g];
      assign m_if[g].add  = madd[g];
      assign m_if[g].be   = mbe[g];
      assign m_if[g].data = mdata[g];
      assign m_if[g].id   = mid[g];
      assign dgnt[g]      = m_if[g].gnt;
      assign drv[g]       = m_if[g].r_valid;
      assign drdat[g]     = m_if[g].r_data;
      assign drid[g]      = m_if[g].r_id;
   end

   assign s_if.gnt     = b_gnt;
   assign s_if.r_valid = b_rv;
   assign s_if.r_data  = b_rdata;
   assign s_if.r_id    = b_rid;

   // Model: is a transaction owned, has it been granted, by whom,
   // and where the next scan starts.
   bit act, gnted;
   int own, ptr;

   int n_vec = 0;
   int n_err = 0;
   int glog[$];

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pick_m();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (mreq[i]) return i;
      end
      return -1;
   endfunction

   task automatic new_req(input int m, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      mreq[m]  = 1'b1;
      mwen[m]  = w;
      madd[m]  = a;
      mdata[m] = d;
      mbe[m]   = 4'($urandom);
      mid[m]   = IDW'($urandom);
   endtask

   task automatic step(input logic g, input logic rv,
                       input logic [31:0] rd,
                       input logic [IDW-1:0] rid);
      bit ereq, eg, erv;
      bit gm [N];
      int p;
      b_gnt   = g;
      b_rv    = rv;
      b_rdata = rd;
      b_rid   = rid;
      #1;
      ereq = act && !gnted;
      chk("out.req", 32'(s_if.req), 32'(ereq));
      if (ereq) begin
         chk("out.add",  s_if.add,         madd[own]);
         chk("out.data", s_if.data,        mdata[own]);
         chk("out.wen",  32'(s_if.wen),    32'(mwen[own]));
         chk("out.be",   32'(s_if.be),     32'(mbe[own]));
         chk("out.id",   32'(s_if.id),     32'(mid[own]));
      end
      for (int m = 0; m < N; m++) begin
         eg    = ereq && g && (own == m);
         erv   = act && (gnted || g) && rv && (own == m);
         gm[m] = eg;
         chk($sformatf("gnt[%0d]", m), 32'(dgnt[m]), 32'(eg));
         chk($sformatf("r_valid[%0d]", m), 32'(drv[m]), 32'(erv));
         chk($sformatf("r_data[%0d]", m), drdat[m],
             erv ? rd : 32'h0);
         chk($sformatf("r_id[%0d]", m), 32'(drid[m]),
             erv ? 32'(rid) : 32'h0);
         if (dgnt[m] === 1'b1) glog.push_back(m);
      end
      chk("busy",  32'(busy),  32'(act));
      chk("owner", 32'(owner), 32'(own));
      if (rst) begin
         act = 0; gnted = 0; own = 0; ptr = 0;
      end else if (!act) begin
         p = pick_m();
         if (p >= 0) begin
            own = p; act = 1; gnted = 0;
         end
      end else if (!gnted) begin
         if (g) begin
            if (rv) begin
               act = 0; ptr = (own + 1) % N;
            end else begin
               gnted = 1;
            end
         end
      end else if (rv) begin
         act = 0; ptr = (own + 1) % N;
      end
      @(posedge clk); #1;
      for (int m = 0; m < N; m++) begin
         if (gm[m]) begin
            mreq[m] = 1'b0;
            if (keep[m])
               new_req(m, 1'b0, $urandom & ~32'h3, $urandom);
         end
      end
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      step(1'b0, 1'b0, 32'h0, '0);
      rst = 1'b0;
   endtask

   task automatic xact_split();
      step(1'b0, 1'b0, $urandom, IDW'($urandom));
      step(1'b1, 1'b0, $urandom, IDW'($urandom));
      step(1'b0, 1'b1, $urandom, IDW'($urandom));
   endtask

   initial begin
      int lvl;
      logic g, rv;
      rst = 1'b1;
      b_gnt = 0; b_rv = 0; b_rdata = '0; b_rid = '0;
      for (int m = 0; m < N; m++) begin
         mreq[m] = 0; mwen[m] = 0; madd[m] = '0; mbe[m] = '0;
         mdata[m] = '0; mid[m] = '0; keep[m] = 0;
      end
      act = 0; gnted = 0; own = 0; ptr = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_pulse();

      // single write from master 0
      new_req(0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF);
      step(1'b0, 1'b0, 32'h0, '0);
      step(1'b0, 1'b0, 32'h0, '0);
      step(1'b1, 1'b0, 32'h0, '0);
      step(1'b0, 1'b1, 32'hCAFE_0001, 8'h1);
      step(1'b0, 1'b0, 32'h0, '0);

      // pointer now at 1: master 1 wins a tie
      glog.delete();
      new_req(0, 1'b0, 32'h10, 32'h1);
      new_req(1, 1'b0, 32'h20, 32'h2);
      xact_split();
      xact_split();
      chk("ptr1_first", 32'(glog.size() > 0 ? glog[0] : 9), 32'd1);

      // tie right after reset: 0 then 1
      rst_pulse();
      glog.delete();
      new_req(0, 1'b0, 32'h30, 32'h3);
      new_req(1, 1'b0, 32'h40, 32'h4);
      xact_split();
      xact_split();
      chk("tie_cnt", 32'(glog.size()), 32'd2);
      chk("tie_0", 32'(glog.size() > 0 ? glog[0] : 9), 32'd0);
      chk("tie_1", 32'(glog.size() > 1 ? glog[1] : 9), 32'd1);

      // continuous requests alternate owners
      rst_pulse();
      glog.delete();
      keep[0] = 1; keep[1] = 1;
      new_req(0, 1'b0, 32'h50, 32'h5);
      new_req(1, 1'b0, 32'h60, 32'h6);
      repeat (6) xact_split();
      keep[0] = 0; keep[1] = 0;
      mreq[0] = 0; mreq[1] = 0;
      chk("alt_cnt", 32'(glog.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("alt_%0d", i),
             32'(glog.size() > i ? glog[i] : 9), 32'(i % 2));

      // read from master 1 with fixed response payload
      rst_pulse();
      new_req(1, 1'b1, 32'h0000_2000, 32'h0);
      step(1'b0, 1'b0, 32'h0, '0);
      step(1'b1, 1'b0, 32'h0, '0);
      step(1'b0, 1'b1, 32'h1234_5678, 8'd3);
      step(1'b0, 1'b0, 32'h0, '0);

      // gnt and r_valid together in FWD
      new_req(0, 1'b1, 32'h0000_3000, 32'h0);
      step(1'b0, 1'b0, 32'h0, '0);
      step(1'b1, 1'b1, 32'hA5A5_5A5A, 8'd7);
      step(1'b0, 1'b0, 32'h0, '0);

      // reset while master 1 waits for its response
      rst_pulse();
      new_req(1, 1'b0, 32'h0000_4000, 32'h77);
      step(1'b0, 1'b0, 32'h0, '0);
      step(1'b1, 1'b0, 32'h0, '0);
      rst_pulse();
      step(1'b0, 1'b1, 32'hBAD0_BAD0, 8'd9);
      new_req(0, 1'b0, 32'h0000_5000, 32'h88);
      xact_split();
      step(1'b0, 1'b0, 32'h0, '0);

      // random traffic with random bridge timing and rare resets
      for (int c = 0; c < 400; c++) begin
         lvl = 3;
         for (int m = 0; m < N; m++)
            if (!mreq[m] && $urandom_range(0, 9) < lvl)
               new_req(m, 1'($urandom), $urandom & ~32'h3, $urandom);
         g  = (act && !gnted) ? 1'($urandom) : 1'b0;
         rv = (act && (gnted || g)) ?
              ($urandom_range(0, 9) < 4) : 1'b0;
         rst = ($urandom_range(0, 63) == 0);
         step(g, rv, $urandom, IDW'($urandom));
         rst = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
